proc_result_arbiter: RTL and testbench



---
 rtl/processor_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 34 +++
 rtl/proc_result_arbiter.sv | 130 +++++++++++++
 tb/tb_proc_result_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/processor_pkg.sv
// Shared types and constants for the processor result path.
// Holds the arbiter state encoding, the result word type and the pointer-width helper.
package processor_pkg;

  localparam int NUM_PROC_DEF = 4;
  localparam int DW_DEF       = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } ARB_STATE_e;

  typedef logic [DW_DEF-1:0] result_t;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first eligible lane at or after rr_ptr, zero latency.
// No backpressure of its own; the caller masks the grant when the sink is full.
module rr_arbiter
  import processor_pkg::*;
#(
  parameter int NUM_PROC = NUM_PROC_DEF,
  parameter int PW       = ptr_w(NUM_PROC)
) (
  input  logic [NUM_PROC-1:0] eligible,
  input  logic [PW-1:0]       rr_ptr,
  output logic [NUM_PROC-1:0] grant,
  output logic [PW-1:0]       winner,
  output logic                any_grant
);

  always_comb begin
    int idx;
    grant     = '0;
    winner    = '0;
    any_grant = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_PROC; k++) begin
      // rr_ptr is always below NUM_PROC, so one subtraction wraps the index
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_PROC) idx = idx - NUM_PROC;
      if (!any_grant && eligible[idx]) begin
        any_grant   = 1'b1;
        winner      = PW'(idx);
        grant[idx]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/proc_result_arbiter.sv
// Per-lane one-entry result buffers sharing one FIFO write port round-robin; req-to-push >= 1 cycle.
// fifo_full stalls all grants and holds the buffers; ARB_STALL_CNT_EN adds the stall_cnt output.
module proc_result_arbiter
  import processor_pkg::*;
#(
  parameter int NUM_PROC = NUM_PROC_DEF,
  parameter int DW       = DW_DEF,
  parameter int CNT_W    = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [2:0]             N,
  input  logic [NUM_PROC-1:0]    req,
  input  logic [NUM_PROC*DW-1:0] data,
  input  logic                   fifo_full,
  output logic                   fifo_push,
  output logic [DW-1:0]          fifo_data,
  output logic [NUM_PROC-1:0]    grant,
  output logic                   busy,
  output logic                   done,
  output logic                   drop_err
`ifdef ARB_STALL_CNT_EN
  ,
  output logic [15:0]            stall_cnt
`endif
);

  localparam int PW = ptr_w(NUM_PROC);

  ARB_STATE_e          state;
  logic [NUM_PROC-1:0] hold_valid;
  logic [DW-1:0]       hold [NUM_PROC];
  logic [PW-1:0]       rr_ptr;
  logic [CNT_W-1:0]    count;
  logic [CNT_W-1:0]    target;

  logic [NUM_PROC-1:0] arb_grant;
  logic [PW-1:0]       winner;
  logic                any_elig;
  logic                wr;
  logic [NUM_PROC-1:0] cap;
  logic [NUM_PROC-1:0] hv_nxt;
  logic                drop_now;
  logic [CNT_W-1:0]    count_nxt;

  rr_arbiter #(
    .NUM_PROC (NUM_PROC),
    .PW       (PW)
  ) u_rr (
    .eligible  (hold_valid),
    .rr_ptr    (rr_ptr),
    .grant     (arb_grant),
    .winner    (winner),
    .any_grant (any_elig)
  );

  assign wr        = any_elig & ~fifo_full;
  assign fifo_push = wr;
  assign grant     = wr ? arb_grant : '0;
  assign fifo_data = wr ? hold[winner] : '0;
  assign busy      = (state == COLLECT);
  assign done      = (state == DONE);
  assign count_nxt = count + CNT_W'(wr);

  // A lane may refill its buffer in the same cycle the old word is granted out.
  always_comb begin
    cap      = '0;
    drop_now = 1'b0;
    hv_nxt   = hold_valid;
    if (wr) hv_nxt[winner] = 1'b0;
    for (int i = 0; i < NUM_PROC; i++) begin
      if (req[i]) begin
        if (state == COLLECT && (!hold_valid[i] || (wr && arb_grant[i])))
          cap[i] = 1'b1;
        else
          drop_now = 1'b1;
      end
    end
    hv_nxt = hv_nxt | cap;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      hold_valid <= '0;
      rr_ptr     <= '0;
      count      <= '0;
      target     <= '0;
      drop_err   <= 1'b0;
    end else begin
      hold_valid <= hv_nxt;
      drop_err   <= drop_err | drop_now;
      count      <= count_nxt;
      if (wr)
        rr_ptr <= (winner == PW'(NUM_PROC - 1)) ? '0 : winner + PW'(1);
      case (state)
        IDLE: begin
          if (start) begin
            target <= CNT_W'(N) * CNT_W'(NUM_PROC);
            count  <= '0;
            state  <= (N == 3'd0) ? DONE : COLLECT;
          end
        end
        COLLECT: begin
          if (count_nxt == target) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PROC; i++)
      if (cap[i]) hold[i] <= data[i*DW +: DW];
  end

`ifdef ARB_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (state == IDLE && start)
      stall_cnt <= '0;
    else if (state == COLLECT && (|hold_valid) && fifo_full && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_proc_result_arbiter.sv
// Bench for proc_result_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_proc_result_arbiter;

  localparam int NP = 4;
  localparam int DW = 16;
`ifdef ARB_STALL_CNT_EN
  localparam int VW = 1 + NP + DW + 3 + 16;
`else
  localparam int VW = 1 + NP + DW + 3;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic fifo_full = 1'b0;
  logic [2:0] N = 3'd0;
  logic [NP-1:0] req = '0;
  logic [NP*DW-1:0] data = '0;
  logic fifo_push;
  logic [DW-1:0] fifo_data;
  logic [NP-1:0] grant;
  logic busy, done, drop_err;
`ifdef ARB_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  proc_result_arbiter #(.NUM_PROC(NP), .DW(DW), .CNT_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .N         (N),
    .req       (req),
    .data      (data),
    .fifo_full (fifo_full),
    .fifo_push (fifo_push),
    .fifo_data (fifo_data),
    .grant     (grant),
    .busy      (busy),
    .done      (done),
    .drop_err  (drop_err)
`ifdef ARB_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  // Reference model: job phase 0=idle 1=collect 2=done, per-lane slot, pointer as plain int.
  int          m_state;
  bit          m_valid [NP];
  logic [DW-1:0] m_hold [NP];
  int          m_ptr, m_count, m_target, m_stall;
  bit          m_drop;

  task automatic model_reset();
    m_state = 0; m_ptr = 0; m_count = 0; m_target = 0; m_stall = 0; m_drop = 0;
    for (int i = 0; i < NP; i++) begin
      m_valid[i] = 0;
      m_hold[i]  = '0;
    end
  endtask

  // One clock: drive inputs, predict outputs, sample DUT at negedge, advance model.
  task automatic step(input bit s, input bit [2:0] n, input bit [NP-1:0] r,
                      input bit [NP*DW-1:0] d, input bit f, input bit rs,
                      output logic [VW-1:0] e, output logic [VW-1:0] a);
    int w, lane;
    bit push, anyv;
    bit vpre [NP];
    logic [NP-1:0] g;
    logic [DW-1:0] ed, ad;
    @(posedge clk);
    #1;
    start = s; N = n; req = r; data = d; fifo_full = f; rst = rs;
    w = -1;
    for (int k = 0; k < NP; k++) begin
      lane = (m_ptr + k) % NP;
      if (w < 0 && m_valid[lane]) w = lane;
    end
    push = (w >= 0) && !f;
    g = '0; ed = '0;
    if (push) begin
      g[w] = 1'b1;
      ed   = m_hold[w];
    end
`ifdef ARB_STALL_CNT_EN
    e = {push, g, ed, m_state == 1, m_state == 2, m_drop, 16'(m_stall)};
`else
    e = {push, g, ed, m_state == 1, m_state == 2, m_drop};
`endif
    @(negedge clk);
    ad = push ? fifo_data : '0;
`ifdef ARB_STALL_CNT_EN
    a = {fifo_push, grant, ad, busy, done, drop_err, stall_cnt};
`else
    a = {fifo_push, grant, ad, busy, done, drop_err};
`endif
    if (rs) begin
      model_reset();
    end else begin
      anyv = 0;
      for (int i = 0; i < NP; i++) begin
        vpre[i] = m_valid[i];
        anyv |= vpre[i];
      end
      if (m_state == 0 && s) m_stall = 0;
      else if (m_state == 1 && anyv && f && m_stall < 65535) m_stall++;
      if (push) begin
        m_valid[w] = 0;
        m_count++;
        m_ptr = (w + 1) % NP;
      end
      for (int i = 0; i < NP; i++) begin
        if (r[i]) begin
          if (m_state == 1 && (!vpre[i] || (push && w == i))) begin
            m_valid[i] = 1;
            m_hold[i]  = d[i*DW +: DW];
          end else begin
            m_drop = 1;
          end
        end
      end
      case (m_state)
        0: if (s) begin
             m_target = n * NP;
             m_count  = 0;
             m_state  = (n == 0) ? 2 : 1;
           end
        1: if (m_count == m_target) m_state = 2;
        default: m_state = 0;
      endcase
    end
  endtask

  task automatic test_reset();
    logic [VW-1:0] e, a;
    model_reset();
    step(0, 0, '0, '0, 0, 1, e, a);
    step(0, 0, '0, '0, 0, 1, e, a);
    step(0, 0, '0, '0, 0, 0, e, a);
    n_tests++;
    if (a !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0", a);
    end
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL reset_model: got %h expected %h", a, e);
    end
  endtask

  task automatic test_basic();
    logic [VW-1:0] e, a;
    logic [DW-1:0] exp_d [4] = '{16'h11, 16'h22, 16'h33, 16'h44};
    logic [DW-1:0] wd [8];
    logic [NP-1:0] wg [8];
    int nw = 0, last_w = -1, done_at = -1;
    bit busy_at [8];
    step(1, 1, '0, '0, 0, 0, e, a);
    n_tests++;
    if (a !== e) begin n_fail++; $display("FAIL basic_start: got %h expected %h", a, e); end
    step(0, 0, 4'hF, {16'h44, 16'h33, 16'h22, 16'h11}, 0, 0, e, a);
    n_tests++;
    if (a !== e) begin n_fail++; $display("FAIL basic_capture: got %h expected %h", a, e); end
    for (int i = 0; i < 8; i++) begin
      step(0, 0, '0, '0, 0, 0, e, a);
      n_tests++;
      if (a !== e) begin n_fail++; $display("FAIL basic_cyc%0d: got %h expected %h", i, a, e); end
      if (fifo_push === 1'b1 && nw < 8) begin
        wd[nw] = fifo_data; wg[nw] = grant; nw++; last_w = i;
      end
      if (done === 1'b1 && done_at < 0) done_at = i;
      busy_at[i] = busy;
    end
    n_tests++;
    if (nw != 4) begin n_fail++; $display("FAIL basic_writes: got %0d expected 4", nw); end
    for (int j = 0; j < 4 && j < nw; j++) begin
      n_tests++;
      if (wd[j] !== exp_d[j] || wg[j] !== NP'(1 << j)) begin
        n_fail++;
        $display("FAIL basic_order%0d: got data %h grant %b expected %h %b", j, wd[j], wg[j], exp_d[j], NP'(1 << j));
      end
    end
    n_tests++;
    if (done_at != last_w + 1 || done_at < 0 || done_at > 6 || busy_at[done_at + 1] !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done: done at %0d last write %0d", done_at, last_w);
    end
  endtask

  task automatic test_backpressure();
    logic [VW-1:0] e, a;
    bit seen_done = 0;
    step(1, 1, '0, '0, 0, 0, e, a);
    step(0, 0, 4'b0111, {16'h0, 16'hC3, 16'hC2, 16'hC1}, 1, 0, e, a);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, '0, '0, 1, 0, e, a);
      n_tests++;
      if (fifo_push !== 1'b0 || grant !== '0 || a !== e) begin
        n_fail++;
        $display("FAIL bp_stall%0d: got %h expected %h", i, a, e);
      end
    end
    for (int j = 0; j < 3; j++) begin
      step(0, 0, '0, '0, 0, 0, e, a);
      n_tests++;
      if (fifo_push !== 1'b1 || grant !== NP'(1 << j) || fifo_data !== DW'(16'hC1 + j) || a !== e) begin
        n_fail++;
        $display("FAIL bp_release%0d: got push %b grant %b data %h expected grant %b", j, fifo_push, grant, fifo_data, NP'(1 << j));
      end
    end
    step(0, 0, 4'b1000, {16'hC4, 48'h0}, 0, 0, e, a);
    for (int i = 0; i < 10 && !seen_done; i++) begin
      step(0, 0, '0, '0, 0, 0, e, a);
      n_tests++;
      if (a !== e) begin n_fail++; $display("FAIL bp_tail%0d: got %h expected %h", i, a, e); end
      if (done === 1'b1) seen_done = 1;
    end
    n_tests++;
    if (!seen_done) begin n_fail++; $display("FAIL bp_done: got no done expected done"); end
    step(0, 0, '0, '0, 0, 0, e, a);
  endtask

  task automatic test_fairness();
    logic [VW-1:0] e, a;
    logic [NP-1:0] rq [9] = '{4'b0001, 4'b0101, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    logic [NP-1:0] order [3] = '{4'b0001, 4'b0100, 4'b0001};
    logic [NP-1:0] gs [12];
    int ng = 0;
    step(0, 0, '0, '0, 0, 1, e, a);
    step(1, 7, '0, '0, 0, 0, e, a);
    for (int i = 0; i < 9; i++) begin
      step(0, 0, rq[i], {NP{DW'(16'hF0 + i)}}, 0, 0, e, a);
      n_tests++;
      if (a !== e) begin n_fail++; $display("FAIL fair_cyc%0d: got %h expected %h", i, a, e); end
      if (fifo_push === 1'b1 && ng < 12) begin gs[ng] = grant; ng++; end
    end
    for (int j = 0; j < 3; j++) begin
      n_tests++;
      if (ng <= j || gs[j] !== order[j]) begin
        n_fail++;
        $display("FAIL fair_order%0d: got %b expected %b", j, (ng > j) ? gs[j] : 'x, order[j]);
      end
    end
    step(0, 0, '0, '0, 0, 1, e, a);
  endtask

  task automatic test_drop();
    logic [VW-1:0] e, a;
    step(1, 1, '0, '0, 0, 0, e, a);
    step(0, 0, 4'b0010, {32'h0, 16'hA1A1, 16'h0}, 1, 0, e, a);
    step(0, 0, 4'b0010, {32'h0, 16'hB2B2, 16'h0}, 1, 0, e, a);
    step(0, 0, '0, '0, 1, 0, e, a);
    n_tests++;
    if (drop_err !== 1'b1 || a !== e) begin n_fail++; $display("FAIL drop_set: got %b expected 1", drop_err); end
    step(0, 0, '0, '0, 0, 0, e, a);
    n_tests++;
    if (fifo_push !== 1'b1 || fifo_data !== 16'hA1A1 || grant !== 4'b0010) begin
      n_fail++;
      $display("FAIL drop_first_word: got push %b data %h grant %b expected 1 a1a1 0010", fifo_push, fifo_data, grant);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, '0, '0, 0, 0, e, a);
      n_tests++;
      if (drop_err !== 1'b1 || fifo_push !== 1'b0 || a !== e) begin
        n_fail++;
        $display("FAIL drop_sticky%0d: got %h expected %h", i, a, e);
      end
    end
    step(0, 0, '0, '0, 0, 1, e, a);
    step(0, 0, '0, '0, 0, 0, e, a);
    n_tests++;
    if (drop_err !== 1'b0) begin n_fail++; $display("FAIL drop_clear: got %b expected 0", drop_err); end
  endtask

  task automatic test_n_zero();
    logic [VW-1:0] e, a;
    step(1, 0, '0, '0, 0, 0, e, a);
    step(0, 0, '0, '0, 0, 0, e, a);
    n_tests++;
    if (done !== 1'b1 || fifo_push !== 1'b0 || busy !== 1'b0 || a !== e) begin
      n_fail++;
      $display("FAIL n0_done: got %h expected %h", a, e);
    end
    step(0, 0, '0, '0, 0, 0, e, a);
    n_tests++;
    if (done !== 1'b0 || a !== e) begin n_fail++; $display("FAIL n0_idle: got %h expected %h", a, e); end
  endtask

  task automatic test_reset_mid();
    logic [VW-1:0] e, a;
    step(1, 2, '0, '0, 0, 0, e, a);
    step(0, 0, 4'b0011, {32'h0, 16'hD2, 16'hD1}, 1, 0, e, a);
    step(0, 0, '0, '0, 1, 0, e, a);
    step(0, 0, '0, '0, 1, 1, e, a);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, '0, '0, 0, 0, e, a);
      n_tests++;
      if (a !== '0 || a !== e) begin n_fail++; $display("FAIL rstmid%0d: got %h expected 0", i, a); end
    end
  endtask

`ifdef ARB_STALL_CNT_EN
  task automatic test_stall();
    logic [VW-1:0] e, a;
    bit seen_done = 0;
    step(1, 1, '0, '0, 0, 0, e, a);
    step(0, 0, 4'hF, {NP{16'h5A5A}}, 1, 0, e, a);
    for (int i = 0; i < 7; i++) step(0, 0, '0, '0, 1, 0, e, a);
    step(0, 0, '0, '0, 0, 0, e, a);
    n_tests++;
    if (stall_cnt !== 16'd7) begin n_fail++; $display("FAIL stall_count: got %0d expected 7", stall_cnt); end
    for (int i = 0; i < 10 && !seen_done; i++) begin
      step(0, 0, '0, '0, 0, 0, e, a);
      if (done === 1'b1) seen_done = 1;
    end
    step(1, 1, '0, '0, 0, 0, e, a);
    step(0, 0, '0, '0, 0, 0, e, a);
    n_tests++;
    if (stall_cnt !== 16'd0 || a !== e) begin n_fail++; $display("FAIL stall_clear: got %0d expected 0", stall_cnt); end
    step(0, 0, '0, '0, 0, 1, e, a);
  endtask
`endif

  task automatic test_random();
    logic [VW-1:0] e, a;
    bit s, f, rs;
    bit [2:0] n;
    bit [NP-1:0] r;
    bit [NP*DW-1:0] d;
    for (int i = 0; i < 1500; i++) begin
      rs = ($urandom_range(0, 199) == 0);
      s  = ($urandom_range(0, 5) == 0);
      n  = 3'($urandom_range(0, 7));
      r  = NP'($urandom & $urandom);
      f  = ($urandom_range(0, 2) == 0);
      for (int k = 0; k < NP; k++) d[k*DW +: DW] = DW'($urandom);
      step(s, n, r, d, f, rs, e, a);
      n_tests++;
      if (a !== e) begin n_fail++; $display("FAIL random_cyc%0d: got %h expected %h", i, a, e); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_fairness();
    test_drop();
    test_n_zero();
    test_reset_mid();
`ifdef ARB_STALL_CNT_EN
    test_stall();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
